// File: rtl/seq_shifter_pkg.sv
// seq_shifter shared definitions: FSM state encoding plus named constants
// for the direction and right-shift fill select bits.
package shift_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  localparam logic DIR_LEFT   = 1'b1;
  localparam logic DIR_RIGHT  = 1'b0;
  localparam logic FILL_LOGIC = 1'b0;
  localparam logic FILL_ARITH = 1'b1;

endpackage

// File: rtl/seq_shifter_if.sv
// seq_shifter operand/result handshake bundle.
// Optional macro SHIFT_ROTATE_EN adds the rot select signal.
interface seq_shifter_if #(
  parameter int W  = 8,
  parameter int SW = $clog2(W)
);

  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  din;
  logic [SW-1:0] shamt;
  logic          LR;
  logic          AL;
`ifdef SHIFT_ROTATE_EN
  logic          rot;
`endif
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  dout;
  logic          busy;

  // Producer/consumer side
  modport master (
`ifdef SHIFT_ROTATE_EN
    output rot,
`endif
    output in_valid, din, shamt, LR, AL, out_ready,
    input  in_ready, out_valid, dout, busy
  );

  // Shifter side
  modport slave (
`ifdef SHIFT_ROTATE_EN
    input  rot,
`endif
    input  in_valid, din, shamt, LR, AL, out_ready,
    output in_ready, out_valid, dout, busy
  );

endinterface

// File: rtl/seq_shifter_step.sv
// shift_step: combinational one-position shifter used by seq_shifter.
// Optional macro SHIFT_ROTATE_EN adds the rotate input.
module shift_step
  import shift_pkg::*;
#(
  parameter int W = 8
) (
  input  logic [W-1:0] q,
  input  logic         lr,
  input  logic         al,
`ifdef SHIFT_ROTATE_EN
  input  logic         rot,
`endif
  output logic [W-1:0] q_nxt
);

  logic in_bit_l;
  logic in_bit_r;

  // Choose the bit entering the vacated end, then move q by one place
  always_comb begin
    in_bit_l = 1'b0;
    in_bit_r = (al == FILL_ARITH) ? q[W-1] : 1'b0;
`ifdef SHIFT_ROTATE_EN
    if (rot) begin
      in_bit_l = q[W-1];
      in_bit_r = q[0];
    end
`endif
    if (lr == DIR_LEFT) q_nxt = {q[W-2:0], in_bit_l};
    else                q_nxt = {in_bit_r, q[W-1:1]};
  end

endmodule

// File: rtl/seq_shifter.sv
// seq_shifter: bit-serial shift unit, one position per clock, with
// valid/ready operand and result ports.
// Optional macro SHIFT_ROTATE_EN enables rotate mode via the rot signal.
module seq_shifter
  import shift_pkg::*;
#(
  parameter int W  = 8,
  parameter int SW = $clog2(W)
) (
  input  logic          clk,
  input  logic          rst_n,
  seq_shifter_if.slave  sif
);

  state_t        state;
  logic [W-1:0]  q;
  logic [W-1:0]  q_nxt;
  logic [SW-1:0] cnt;
  logic          lr_q;
  logic          al_q;
`ifdef SHIFT_ROTATE_EN
  logic          rot_q;
`endif
  logic          in_ready_r;
  logic          out_valid_r;
  logic          busy_r;

  shift_step #(.W(W)) u_step (
    .q     (q),
    .lr    (lr_q),
    .al    (al_q),
`ifdef SHIFT_ROTATE_EN
    .rot   (rot_q),
`endif
    .q_nxt (q_nxt)
  );

  assign sif.dout      = q;
  assign sif.in_ready  = in_ready_r;
  assign sif.out_valid = out_valid_r;
  assign sif.busy      = busy_r;

  // Control FSM and shift register; handshake flags are registered with the state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      q           <= '0;
      cnt         <= '0;
      lr_q        <= DIR_RIGHT;
      al_q        <= FILL_LOGIC;
`ifdef SHIFT_ROTATE_EN
      rot_q       <= 1'b0;
`endif
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
      busy_r      <= 1'b0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (sif.in_valid) begin
            q          <= sif.din;
            cnt        <= sif.shamt;
            lr_q       <= sif.LR;
            al_q       <= sif.AL;
`ifdef SHIFT_ROTATE_EN
            rot_q      <= sif.rot;
`endif
            in_ready_r <= 1'b0;
            busy_r     <= 1'b1;
            // A zero shift has nothing to do and goes straight to the result
            if (sif.shamt == '0) begin
              state       <= S_DONE;
              out_valid_r <= 1'b1;
            end else begin
              state <= S_SHIFT;
            end
          end
        end
        S_SHIFT: begin
          q   <= q_nxt;
          cnt <= cnt - SW'(1);
          if (cnt == SW'(1)) begin
            state       <= S_DONE;
            out_valid_r <= 1'b1;
          end
        end
        S_DONE: begin
          // Return to IDLE only; the next accept is one cycle later
          if (sif.out_ready) begin
            state       <= S_IDLE;
            out_valid_r <= 1'b0;
            in_ready_r  <= 1'b1;
            busy_r      <= 1'b0;
          end
        end
        default: begin
          state       <= S_IDLE;
          out_valid_r <= 1'b0;
          in_ready_r  <= 1'b1;
          busy_r      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_shifter.sv
// Self-checking bench for seq_shifter (W=8). A transaction-level model
// computes each result arithmetically at acceptance and tracks how many
// edges remain before it is due; a compare process checks it every cycle.
module tb_seq_shifter;

  localparam int W  = 8;
  localparam int SW = 3;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  seq_shifter_if #(.W(W), .SW(SW)) bus ();

  seq_shifter #(.W(W), .SW(SW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .sif   (bus)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference result from the arithmetic definition of each operation
  function automatic logic [7:0] ref_shift(input logic [7:0] d, input int s,
                                           input bit lr, input bit al, input bit rt);
    logic [15:0]       dd;
    logic signed [7:0] sd;
    if (rt) begin
      dd = {d, d};
      if (lr) begin dd = dd << s; return dd[15:8]; end
      else    begin dd = dd >> s; return dd[7:0];  end
    end
    if (lr) return 8'(d << s);
    if (al) begin sd = d; sd = sd >>> s; return sd; end
    return d >> s;
  endfunction

  // Model: free -> pending result (edges_left counts down) -> result ready
  bit         m_free;
  bit         m_ready;
  int         m_edges_left;
  logic [7:0] m_res;
  bit         m_rot_in;

`ifdef SHIFT_ROTATE_EN
  assign m_rot_in = bus.rot;
`else
  assign m_rot_in = 1'b0;
`endif

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_free       <= 1'b1;
      m_ready      <= 1'b0;
      m_edges_left <= 0;
      m_res        <= 8'h00;
    end else if (m_free) begin
      if (bus.in_valid) begin
        m_res        <= ref_shift(bus.din, int'(bus.shamt), bus.LR, bus.AL, m_rot_in);
        m_free       <= 1'b0;
        m_edges_left <= int'(bus.shamt);
        m_ready      <= (bus.shamt == 0);
      end
    end else if (!m_ready) begin
      m_edges_left <= m_edges_left - 1;
      if (m_edges_left == 1) m_ready <= 1'b1;
    end else if (bus.out_ready) begin
      m_ready <= 1'b0;
      m_free  <= 1'b1;
    end
  end

  // Per-cycle comparison against the model
  always @(negedge clk) begin
    if (rst_n) begin
      check("in_ready", bus.in_ready, m_free);
      check("out_valid", bus.out_valid, m_ready);
      check("busy", bus.busy, !m_free);
      if (m_ready) check("dout", bus.dout, m_res);
    end
  end

  // One operation: accept, count edges to out_valid, check result, optional backpressure
  task automatic run_op(input string nm, input logic [7:0] d, input int s,
                        input bit lr, input bit al, input logic [7:0] exp, input int hold);
    int edges;
    int guard;
    edges = 0;
    guard = 0;
    @(negedge clk);
    while (!bus.in_ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    if (!bus.in_ready) begin
      check({nm, "_ready_timeout"}, 0, 1);
      return;
    end
    bus.din      = d;
    bus.shamt    = s[2:0];
    bus.LR       = lr;
    bus.AL       = al;
    bus.in_valid = 1'b1;
    @(posedge clk);
    edges = 1;
    #1;
    // Operand changes after acceptance must not matter
    bus.in_valid = 1'b0;
    bus.din      = ~d;
    bus.shamt    = 3'd5;
    bus.LR       = ~lr;
    bus.AL       = ~al;
    while (!bus.out_valid && edges < 40) begin
      check({nm, "_busy"}, bus.busy, 1);
      @(posedge clk);
      edges++;
      #1;
    end
    check({nm, "_latency"}, edges, s + 1);
    check({nm, "_result"}, bus.dout, exp);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      bus.in_valid = ~bus.in_valid;
      bus.din      = 8'($urandom);
      #1;
      check({nm, "_hold_dout"}, bus.dout, exp);
      check({nm, "_hold_in_ready"}, bus.in_ready, 0);
      check({nm, "_hold_out_valid"}, bus.out_valid, 1);
    end
    bus.in_valid = 1'b0;
    @(negedge clk);
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.din       = 8'h00;
    bus.shamt     = 3'd0;
    bus.LR        = 1'b0;
    bus.AL        = 1'b0;
    bus.out_ready = 1'b0;
`ifdef SHIFT_ROTATE_EN
    bus.rot       = 1'b0;
`endif
    #12;
    check("rst_in_ready", bus.in_ready, 1);
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_dout", bus.dout, 8'h00);
    #1 rst_n = 1'b1;

    // Model pinned by hand-computed literals
    check("ref_asr", ref_shift(8'b1001_0110, 3, 1'b0, 1'b1, 1'b0), 8'b1111_0010);
    check("ref_lsr", ref_shift(8'b1001_0110, 3, 1'b0, 1'b0, 1'b0), 8'b0001_0010);
    check("ref_lsl", ref_shift(8'hFF, 7, 1'b1, 1'b0, 1'b0), 8'h80);

    run_op("asr3", 8'b1001_0110, 3, 1'b0, 1'b1, 8'b1111_0010, 0);
    run_op("lsr3", 8'b1001_0110, 3, 1'b0, 1'b0, 8'b0001_0010, 0);
    run_op("lsl7", 8'hFF, 7, 1'b1, 1'b0, 8'h80, 0);
    run_op("zero_bp", 8'hA5, 0, 1'b0, 1'b0, 8'hA5, 5);
    run_op("asr7", 8'h80, 7, 1'b0, 1'b1, 8'hFF, 0);
    run_op("lsr7", 8'h80, 7, 1'b0, 1'b0, 8'h01, 0);
    run_op("lsl4_al", 8'h0F, 4, 1'b1, 1'b1, 8'hF0, 0);
    run_op("lsl1", 8'h81, 1, 1'b1, 1'b0, 8'h02, 2);
    run_op("asr1_pos", 8'h7E, 1, 1'b0, 1'b1, 8'h3F, 0);

`ifdef SHIFT_ROTATE_EN
    check("ref_rol", ref_shift(8'h81, 1, 1'b1, 1'b0, 1'b1), 8'h03);
    check("ref_ror", ref_shift(8'h81, 1, 1'b0, 1'b0, 1'b1), 8'hC0);
    bus.rot = 1'b1;
    run_op("rol1", 8'h81, 1, 1'b1, 1'b0, 8'h03, 0);
    run_op("ror1", 8'h81, 1, 1'b0, 1'b1, 8'hC0, 0);
    run_op("ror5", 8'hB4, 5, 1'b0, 1'b0, 8'hA5, 0);
    bus.rot = 1'b0;
`endif

    // Reset in the middle of a shift discards the operation
    @(negedge clk);
    bus.din      = 8'h3C;
    bus.shamt    = 3'd6;
    bus.LR       = 1'b1;
    bus.AL       = 1'b0;
    bus.in_valid = 1'b1;
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("midrst_out_valid", bus.out_valid, 0);
    check("midrst_dout", bus.dout, 8'h00);
    check("midrst_in_ready", bus.in_ready, 1);
    check("midrst_busy", bus.busy, 0);
    #2 rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("postrst_no_result", bus.out_valid, 0);
    end

    run_op("after_rst", 8'h3C, 2, 1'b1, 1'b0, 8'hF0, 0);
    repeat (3) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
